// File: rtl/store_pkg.sv
// Shared definitions for the store narrowing buffer.
//
// Contents:
//   st_size_e      - encodings of the st_size field (sb / sh / sw / reserved)
//   store_entry_t  - one buffered memory write {addr, wdata, be}
//   pack_lanes     - turns a right-aligned register store into a
//                    lane-replicated word write with byte enables
//   is_misaligned  - true when a half/word store is not naturally aligned
//
// Misaligned half/word stores are force-aligned by pack_lanes because it
// never looks at the address bits below the access size.
package store_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } st_size_e;

    typedef struct packed {
        logic [29:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } store_entry_t;

    // Reserved size 11 falls into the default arm and behaves as a word.
    function automatic store_entry_t pack_lanes(input logic [31:0] addr,
                                                input logic [31:0] data,
                                                input logic [1:0]  size);
        store_entry_t e;
        e.addr = addr[31:2];
        case (st_size_e'(size))
            SIZE_BYTE: begin
                e.wdata = {4{data[7:0]}};
                e.be    = 4'b0001 << addr[1:0];
            end
            SIZE_HALF: begin
                e.wdata = {2{data[15:0]}};
                e.be    = addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                e.wdata = data;
                e.be    = 4'b1111;
            end
        endcase
        return e;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] addr_lo,
                                           input logic [1:0] size);
        logic mis;
        case (st_size_e'(size))
            SIZE_BYTE: mis = 1'b0;
            SIZE_HALF: mis = addr_lo[0];
            default:   mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/store_lane_pack.sv
// Combinational lane packer sitting on the enqueue path of the buffer.
//
// Ports:
//   addr       in  [31:0]  byte address of the store
//   data       in  [31:0]  register value, right-aligned
//   size       in  [1:0]   st_size encoding
//   word_addr  out [29:0]  word address (addr[31:2])
//   wdata      out [31:0]  lane-replicated write data
//   be         out [3:0]   byte enables, bit i = byte lane i
//   misaligned out         only with STORE_MISALIGN_TRAP_EN: store is not
//                          naturally aligned for its size
//
// Configuration macro: STORE_MISALIGN_TRAP_EN
module store_lane_pack
    import store_pkg::*;
(
    input  logic [31:0] addr,
    input  logic [31:0] data,
    input  logic [1:0]  size,
    output logic [29:0] word_addr,
    output logic [31:0] wdata,
    output logic [3:0]  be
`ifdef STORE_MISALIGN_TRAP_EN
    ,
    output logic        misaligned
`endif
);

    store_entry_t packed_entry;

    // All narrowing rules live in the package function so the struct layout
    // and the lane rules stay in one place.
    always_comb begin
        packed_entry = pack_lanes(addr, data, size);
        word_addr    = packed_entry.addr;
        wdata        = packed_entry.wdata;
        be           = packed_entry.be;
    end

`ifdef STORE_MISALIGN_TRAP_EN
    always_comb begin
        misaligned = is_misaligned(addr[1:0], size);
    end
`endif

endmodule

// File: rtl/store_narrow_buffer.sv
// Store buffer that narrows sb/sh/sw register stores into word-wide memory
// writes and queues them in FIFO order toward data memory.
//
// Ports:
//   clk, rst_n     clock (rising edge) and asynchronous active-low reset
//   st_valid/ready store request handshake; ready is simply "not full"
//   st_addr        byte address, st_data right-aligned value, st_size size
//   mem_valid/ready head-of-queue handshake toward data memory
//   mem_addr       word address, mem_wdata lane-replicated data, mem_be enables
//   buf_empty      no entries held
//   misalign_err   only with STORE_MISALIGN_TRAP_EN: one-cycle registered
//                  pulse after a misaligned store was accepted and dropped
//
// Configuration macro: STORE_MISALIGN_TRAP_EN
// Without it misaligned half/word stores are force-aligned.
module store_narrow_buffer
    import store_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [1:0]  st_size,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic        buf_empty
`ifdef STORE_MISALIGN_TRAP_EN
    ,
    output logic        misalign_err
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    store_entry_t     entries [DEPTH];
    store_entry_t     head_entry;
    store_entry_t     new_entry;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             push;
    logic             pop;
    logic             enq;
    logic [29:0]      pack_addr;
    logic [31:0]      pack_wdata;
    logic [3:0]       pack_be;

`ifdef STORE_MISALIGN_TRAP_EN
    logic             pack_misaligned;
`endif

    store_lane_pack u_lane_pack (
        .addr       (st_addr),
        .data       (st_data),
        .size       (st_size),
        .word_addr  (pack_addr),
        .wdata      (pack_wdata),
        .be         (pack_be)
`ifdef STORE_MISALIGN_TRAP_EN
        ,
        .misaligned (pack_misaligned)
`endif
    );

    // Handshakes. Since st_ready is only !full, a full buffer refuses a push
    // even when the head pops in the same cycle. A misaligned store in trap
    // mode completes its handshake but never reaches the queue.
    always_comb begin
        full       = (count == FULL_COUNT);
        st_ready   = !full;
        mem_valid  = (count != '0);
        buf_empty  = (count == '0);
        push       = st_valid && st_ready;
        pop        = mem_valid && mem_ready;
`ifdef STORE_MISALIGN_TRAP_EN
        enq        = push && !pack_misaligned;
`else
        enq        = push;
`endif
        new_entry  = '{addr: pack_addr, wdata: pack_wdata, be: pack_be};
        head_entry = entries[rd_ptr];
        mem_addr   = head_entry.addr;
        mem_wdata  = head_entry.wdata;
        mem_be     = head_entry.be;
    end

    // Entry storage carries no reset; count governs which slots are live,
    // so stale contents are never presented after a reset.
    always_ff @(posedge clk) begin
        if (enq) begin
            entries[wr_ptr] <= new_entry;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Occupancy: a simultaneous enqueue and pop leaves it unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            case ({enq, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef STORE_MISALIGN_TRAP_EN
    // One-cycle registered flag for a dropped misaligned store.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= push && pack_misaligned;
        end
    end
`endif

endmodule

// File: tb/tb_store_narrow_buffer.sv
// Self-checking bench for store_narrow_buffer (DEPTH = 4).
// Directed scenarios followed by randomized traffic, all checked against a
// queue-based reference model built from the narrowing rules.
// Works in both builds; define STORE_MISALIGN_TRAP_EN to exercise the trap.
module tb_store_narrow_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [1:0]  st_size;
    logic        mem_valid;
    logic        mem_ready;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        buf_empty;
`ifdef STORE_MISALIGN_TRAP_EN
    logic        misalign_err;
    logic        exp_err;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [29:0] a;
        logic [31:0] d;
        logic [3:0]  be;
    } exp_t;

    exp_t model_q[$];

    always #5 clk = ~clk;

    store_narrow_buffer #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .st_valid     (st_valid),
        .st_ready     (st_ready),
        .st_addr      (st_addr),
        .st_data      (st_data),
        .st_size      (st_size),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_be       (mem_be),
        .buf_empty    (buf_empty)
`ifdef STORE_MISALIGN_TRAP_EN
        ,
        .misalign_err (misalign_err)
`endif
    );

    // Reference narrowing: what memory should see for a given store.
    function automatic exp_t model_pack(input logic [31:0] a, input logic [31:0] d,
                                        input logic [1:0] sz);
        exp_t e;
        logic [1:0] lo;
        lo   = a[1:0];
        e.a  = a[31:2];
        if (sz == 2'd0) begin
            e.d  = {d[7:0], d[7:0], d[7:0], d[7:0]};
            e.be = 4'(1 << lo);
        end else if (sz == 2'd1) begin
            e.d  = {d[15:0], d[15:0]};
            e.be = (lo >= 2) ? 4'hC : 4'h3;
        end else begin
            e.d  = d;
            e.be = 4'hF;
        end
        return e;
    endfunction

    function automatic logic model_mis(input logic [31:0] a, input logic [1:0] sz);
        if (sz == 2'd0) return 1'b0;
        if (sz == 2'd1) return (a % 2) != 0;
        return (a % 4) != 0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_output();
        check("buf_empty", 32'(buf_empty), 32'(model_q.size() == 0));
        check("mem_valid", 32'(mem_valid), 32'(model_q.size() != 0));
        check("st_ready", 32'(st_ready), 32'(model_q.size() < DEPTH));
        if (model_q.size() != 0) begin
            check("mem_addr", 32'(mem_addr), 32'(model_q[0].a));
            check("mem_wdata", mem_wdata, model_q[0].d);
            check("mem_be", 32'(mem_be), 32'(model_q[0].be));
        end
`ifdef STORE_MISALIGN_TRAP_EN
        check("misalign_err", 32'(misalign_err), 32'(exp_err));
`endif
    endtask

    // One clock cycle: called just after a falling edge, drives inputs,
    // checks outputs (nothing may bypass to mem_*), advances the model.
    task automatic apply_stimulus(input logic v, input logic [31:0] a, input logic [31:0] d,
                                  input logic [1:0] sz, input logic mr);
        logic can_push;
        logic do_pop;
        st_valid  = v;
        st_addr   = a;
        st_data   = d;
        st_size   = sz;
        mem_ready = mr;
        #1;
        check_output();
        can_push = v && (model_q.size() < DEPTH);
        do_pop   = mr && (model_q.size() != 0);
        if (do_pop) void'(model_q.pop_front());
`ifdef STORE_MISALIGN_TRAP_EN
        exp_err = can_push && model_mis(a, sz);
        if (can_push && !model_mis(a, sz)) model_q.push_back(model_pack(a, d, sz));
`else
        if (can_push) model_q.push_back(model_pack(a, d, sz));
`endif
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input logic mr);
        apply_stimulus(1'b0, 32'h0, 32'h0, 2'd0, mr);
    endtask

    initial begin
        logic [31:0] order [$];
        logic [31:0] ra;
        logic [31:0] rd;

        rst_n     = 1'b0;
        st_valid  = 1'b0;
        st_addr   = '0;
        st_data   = '0;
        st_size   = '0;
        mem_ready = 1'b0;
`ifdef STORE_MISALIGN_TRAP_EN
        exp_err   = 1'b0;
`endif
        #1;
        check("rst_buf_empty", 32'(buf_empty), 32'd1);
        check("rst_mem_valid", 32'(mem_valid), 32'd0);
        check("rst_st_ready", 32'(st_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Byte store to the top lane, visible one cycle later.
        apply_stimulus(1'b1, 32'h0000_1003, 32'h0000_00AB, 2'd0, 1'b0);
        check("sb_valid", 32'(mem_valid), 32'd1);
        check("sb_addr", 32'(mem_addr), 32'h0000_0400);
        check("sb_wdata", mem_wdata, 32'hABAB_ABAB);
        check("sb_be", 32'(mem_be), 32'h8);
        idle(1'b1);

        // Half store to the upper half.
        apply_stimulus(1'b1, 32'h0000_2002, 32'hFFFF_1234, 2'd1, 1'b0);
        check("sh_wdata", mem_wdata, 32'h1234_1234);
        check("sh_be", 32'(mem_be), 32'hC);
        check("sh_addr", 32'(mem_addr), 32'h0000_0800);
        idle(1'b1);

        // Fill with stalled memory, then pop and push together while full.
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b1, 32'h100 + 32'(i * 4), 32'hA000_0000 + 32'(i), 2'd2, 1'b0);
        end
        check("full_st_ready", 32'(st_ready), 32'd0);
        apply_stimulus(1'b1, 32'h200, 32'hA000_0005, 2'd2, 1'b0);
        check("held_head", mem_wdata, 32'hA000_0000);
        apply_stimulus(1'b1, 32'h200, 32'hA000_0005, 2'd2, 1'b1);
        check("full_pop_ready", 32'(st_ready), 32'd1);
        check("full_pop_head", mem_wdata, 32'hA000_0001);
        apply_stimulus(1'b1, 32'h200, 32'hA000_0005, 2'd2, 1'b1);
        order = '{32'hA000_0002, 32'hA000_0003, 32'hA000_0005};
        foreach (order[k]) begin
            check("drain_order", mem_wdata, order[k]);
            idle(1'b1);
        end
        check("drain_empty", 32'(buf_empty), 32'd1);

        // Misaligned word store.
        apply_stimulus(1'b1, 32'h0000_0006, 32'hCAFE_F00D, 2'd2, 1'b0);
`ifdef STORE_MISALIGN_TRAP_EN
        check("mis_err", 32'(misalign_err), 32'd1);
        check("mis_empty", 32'(buf_empty), 32'd1);
        idle(1'b0);
        check("mis_err_pulse", 32'(misalign_err), 32'd0);
`else
        check("mis_be", 32'(mem_be), 32'hF);
        check("mis_addr", 32'(mem_addr), 32'h0000_0001);
        check("mis_wdata", mem_wdata, 32'hCAFE_F00D);
        idle(1'b1);
`endif
        idle(1'b0);

        // Reset with two entries held.
        apply_stimulus(1'b1, 32'h0000_0300, 32'h1111_1111, 2'd2, 1'b0);
        apply_stimulus(1'b1, 32'h0000_0304, 32'h2222_2222, 2'd2, 1'b0);
        st_valid = 1'b0;
        check("pre_rst_valid", 32'(mem_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(mem_valid), 32'd0);
        check("mid_rst_empty", 32'(buf_empty), 32'd1);
        check("mid_rst_ready", 32'(st_ready), 32'd1);
`ifdef STORE_MISALIGN_TRAP_EN
        check("mid_rst_err", 32'(misalign_err), 32'd0);
        exp_err = 1'b0;
`endif
        model_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) idle(1'b1);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            ra = $urandom;
            rd = $urandom;
            apply_stimulus(1'($urandom_range(0, 1)), ra, rd, 2'($urandom_range(0, 3)),
                           1'($urandom_range(0, 2) != 0));
        end
        repeat (DEPTH + 2) idle(1'b1);
        check_output();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
